yolo_out_serializer: RTL

- Downstream neighbour of the YOLOv3-Tiny core output FIFO.
- Accepts one wide detection vector per handshake (NUM_WORDS words of WORD_WIDTH bits; 255 = 3 anchors x 85 values).
- Streams the vector out one word per beat over a valid/ready interface toward the bus/DMA side.
- Its ready_out drives the output FIFO's Dequeue, so the core is back-pressured through the FIFO Full flag instead of popping unconditionally.

---
 rtl/yolo_out_serializer_pkg.sv | 14 +
 rtl/yolo_out_serializer.sv | 108 ++++++++++
 2 files changed

// File: rtl/yolo_out_serializer_pkg.sv
// Shared YOLOv3-Tiny output constants and the serializer state type.
package yolo_pkg;

    localparam int YOLO_WORD_W    = 32;
    localparam int YOLO_NUM_ANCH  = 3;
    localparam int YOLO_NUM_CLS   = 80;
    localparam int YOLO_OUT_WORDS = YOLO_NUM_ANCH * (YOLO_NUM_CLS + 5);

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/yolo_out_serializer.sv
// Streams one wide detection vector from the core output FIFO as a sequence
// of words over valid/ready, back-pressuring the FIFO through ready_out.
module yolo_out_serializer
    import yolo_pkg::*;
#(
    parameter int WORD_WIDTH  = YOLO_WORD_W,
    parameter int NUM_WORDS   = YOLO_OUT_WORDS,
    parameter int CNT_W       = $clog2(NUM_WORDS),
    parameter int FRAME_CNT_W = 16
) (
    input  logic                            Clk,
    input  logic                            Rst_N,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] data_in,
    input  logic                            valid_in,
    output logic                            ready_out,
    output logic [WORD_WIDTH-1:0]           data_out,
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic                            last_out,
    output logic                            busy,
    output logic [FRAME_CNT_W-1:0]          frame_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    ser_state_t                      state_q, state_d;
    logic [CNT_W-1:0]                idx_q, idx_d;
    logic [NUM_WORDS*WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [FRAME_CNT_W-1:0]          frame_q, frame_d;

    logic send_s;
    logic last_s;
    logic beat_s;
    logic load_s;

    assign send_s = (state_q == SER_SEND);
    assign last_s = send_s && (idx_q == LAST_IDX);
    assign beat_s = send_s && ready_in;

    // The FIFO may be popped in IDLE, or on the final beat so the next
    // vector follows without a bubble; valid_in is deliberately not used.
    assign ready_out = (state_q == SER_IDLE) || (last_s && ready_in);
    assign load_s    = valid_in && ready_out;

    assign data_out  = shreg_q[WORD_WIDTH-1:0];
    assign valid_out = send_s;
    assign last_out  = last_s;
    assign busy      = send_s;
    assign frame_cnt = frame_q;

    // Next-state logic for the FSM, beat index, shift register and frame counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        frame_d = frame_q;
        case (state_q)
            SER_IDLE: begin
                if (load_s) begin
                    shreg_d = data_in;
                    idx_d   = {CNT_W{1'b0}};
                    state_d = SER_SEND;
                end else begin
                    state_d = SER_IDLE;
                end
            end
            SER_SEND: begin
                if (beat_s && !last_s) begin
                    shreg_d = shreg_q >> WORD_WIDTH;
                    idx_d   = idx_q + CNT_W'(1);
                end else if (beat_s) begin
                    frame_d = frame_q + FRAME_CNT_W'(1);
                    idx_d   = {CNT_W{1'b0}};
                    if (load_s) begin
                        shreg_d = data_in;
                        state_d = SER_SEND;
                    end else begin
                        shreg_d = {(NUM_WORDS*WORD_WIDTH){1'b0}};
                        state_d = SER_IDLE;
                    end
                end else begin
                    state_d = SER_SEND;
                end
            end
            default: begin
                state_d = SER_IDLE;
                idx_d   = {CNT_W{1'b0}};
                shreg_d = {(NUM_WORDS*WORD_WIDTH){1'b0}};
            end
        endcase
    end

    // State registers; reset discards any partially sent vector.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q <= SER_IDLE;
            idx_q   <= {CNT_W{1'b0}};
            shreg_q <= {(NUM_WORDS*WORD_WIDTH){1'b0}};
            frame_q <= {FRAME_CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            frame_q <= frame_d;
        end
    end

endmodule
